// File: rtl/dma_bus_arbiter_pkg.sv
// rtl/dma_bus_arbiter_pkg.sv - shared constants and state encoding for the DMA bus arbiter
package dma_bus_arbiter_pkg;

  localparam int DEF_WORD_SIZE = 16;
  localparam int DEF_MAX_GRANT = 64;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_CPU = 2'd1,
    ST_GRANT    = 2'd2,
    ST_RELEASE  = 2'd3
  } arb_state_e;

  // DMA burst layout: 12-word transfer moved as 4-word bursts from a fixed base
  localparam logic [15:0] DMA_BASE_ADDR   = 16'h01F4;
  localparam int          DMA_LEN_WORDS   = 12;
  localparam int          DMA_BURST_WORDS = 4;

  function automatic logic [15:0] dma_burst_addr(input logic [15:0] idx);
    return DMA_BASE_ADDR + idx * 16'(DMA_BURST_WORDS);
  endfunction

endpackage

// File: rtl/dma_bus_arbiter.sv
// rtl/dma_bus_arbiter.sv - CPU/DMA shared memory port arbiter with grant timeout
module dma_bus_arbiter
  import dma_bus_arbiter_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int MAX_GRANT = DEF_MAX_GRANT
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic                   BR,
  output logic                   BG,
  input  logic                   cpu_mem_busy,
  input  logic                   cpu_mem_req,
  output logic                   cpu_stall,
  input  logic [WORD_SIZE-1:0]   cpu_addr,
  input  logic [4*WORD_SIZE-1:0] cpu_data,
  input  logic                   cpu_write,
  input  logic [WORD_SIZE-1:0]   dma_addr,
  input  logic [4*WORD_SIZE-1:0] dma_data,
  input  logic                   dma_write,
  output logic [WORD_SIZE-1:0]   mem_addr,
  output logic [4*WORD_SIZE-1:0] mem_data,
  output logic                   mem_write,
  output logic                   dma_end,
  output logic                   grant_timeout
);

  localparam int              CNT_W    = $clog2(MAX_GRANT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_GRANT - 1);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bg_q, dma_end_q, dma_end_d, timeout_q, timeout_set;

  // A new CPU request needs no special handling: stall already covers the tie with BR.
  logic unused_cpu_mem_req;
  assign unused_cpu_mem_req = cpu_mem_req;

  always_comb begin
    state_d     = state_q;
    dma_end_d   = 1'b0;
    timeout_set = 1'b0;
    cnt_d       = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (BR) state_d = cpu_mem_busy ? ST_WAIT_CPU : ST_GRANT;
      end
      ST_WAIT_CPU: begin
        if (!BR)               state_d = ST_IDLE;
        else if (!cpu_mem_busy) state_d = ST_GRANT;
      end
      ST_GRANT: begin
        cnt_d = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + 1'b1;
        if (!BR) begin
          state_d   = ST_RELEASE;
          dma_end_d = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = ST_RELEASE;
          timeout_set = 1'b1;
        end
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bg_q      <= 1'b0;
      dma_end_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bg_q      <= (state_d == ST_GRANT);
      dma_end_q <= dma_end_d;
      timeout_q <= timeout_q | timeout_set;
    end
  end

  assign BG            = bg_q;
  assign dma_end       = dma_end_q;
  assign grant_timeout = timeout_q;
  assign cpu_stall     = (state_q != ST_IDLE) | BR;

  // RELEASE keeps the CPU address on the bus but blocks writes for one turnaround cycle.
  always_comb begin
    mem_addr  = cpu_addr;
    mem_data  = cpu_data;
    mem_write = cpu_write;
    if (state_q == ST_GRANT) begin
      mem_addr  = dma_addr;
      mem_data  = dma_data;
      mem_write = dma_write;
    end else if (state_q == ST_RELEASE) begin
      mem_write = 1'b0;
    end
  end

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// tb/tb_dma_bus_arbiter.sv - directed self-checking bench for dma_bus_arbiter
module tb_dma_bus_arbiter;

  localparam int WS = 16;

  logic          CLK = 1'b0;
  logic          reset, BR, cpu_mem_busy, cpu_mem_req, cpu_write, dma_write;
  logic [WS-1:0] cpu_addr, dma_addr;
  logic [4*WS-1:0] cpu_data, dma_data;
  logic          BG, cpu_stall, mem_write, dma_end, grant_timeout;
  logic [WS-1:0] mem_addr;
  logic [4*WS-1:0] mem_data;

  int passed = 0;
  int total  = 0;

  dma_bus_arbiter #(.WORD_SIZE(WS), .MAX_GRANT(4)) dut (
    .CLK(CLK), .reset(reset), .BR(BR), .BG(BG),
    .cpu_mem_busy(cpu_mem_busy), .cpu_mem_req(cpu_mem_req), .cpu_stall(cpu_stall),
    .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_write(cpu_write),
    .dma_addr(dma_addr), .dma_data(dma_data), .dma_write(dma_write),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_write(mem_write),
    .dma_end(dma_end), .grant_timeout(grant_timeout)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample();
    @(negedge CLK);
  endtask

  task automatic test_reset();
    reset = 1'b1; BR = 1'b0; cpu_mem_busy = 1'b0; cpu_mem_req = 1'b0;
    cpu_write = 1'b1; dma_write = 1'b0;
    cpu_addr = 16'h1000; cpu_data = 64'h1111_2222_3333_4444;
    dma_addr = 16'h0000; dma_data = 64'hAAAA_BBBB_CCCC_DDDD;
    tick(); tick();
    sample();
    total++; if (BG !== 1'b0) $display("FAIL reset_bg: got %b want 0", BG); else passed++;
    total++; if (dma_end !== 1'b0) $display("FAIL reset_dma_end: got %b want 0", dma_end); else passed++;
    total++; if (grant_timeout !== 1'b0) $display("FAIL reset_timeout: got %b want 0", grant_timeout); else passed++;
    total++; if (cpu_stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", cpu_stall); else passed++;
    total++; if (mem_addr !== 16'h1000) $display("FAIL reset_mem_addr: got %h want 1000", mem_addr); else passed++;
    total++; if (mem_write !== 1'b1) $display("FAIL reset_mem_write: got %b want 1", mem_write); else passed++;
    BR = 1'b1;
    sample();
    total++; if (cpu_stall !== 1'b1) $display("FAIL reset_stall_follows_br: got %b want 1", cpu_stall); else passed++;
    tick();
    BR = 1'b0; reset = 1'b0; cpu_write = 1'b0;
    tick();
  endtask

  task automatic test_basic_grant();
    logic [WS-1:0] addrs [3];
    addrs[0] = 16'h01F4; addrs[1] = 16'h01F8; addrs[2] = 16'h01FC;
    BR = 1'b1;
    sample();
    total++; if (BG !== 1'b0) $display("FAIL basic_bg_latency: got %b want 0", BG); else passed++;
    total++; if (mem_addr !== 16'h1000) $display("FAIL basic_mux_idle: got %h want 1000", mem_addr); else passed++;
    for (int i = 0; i < 3; i++) begin
      tick();
      dma_addr = addrs[i]; dma_data = 64'h0D0D_0000_0000_0000 + 64'(i); dma_write = 1'b1;
      if (i == 2) BR = 1'b0;
      sample();
      total++; if (BG !== 1'b1) $display("FAIL basic_bg%0d: got %b want 1", i, BG); else passed++;
      total++; if (mem_addr !== addrs[i]) $display("FAIL basic_mem_addr%0d: got %h want %h", i, mem_addr, addrs[i]); else passed++;
      total++; if (mem_data !== 64'h0D0D_0000_0000_0000 + 64'(i)) $display("FAIL basic_mem_data%0d: got %h", i, mem_data); else passed++;
      total++; if (mem_write !== 1'b1) $display("FAIL basic_mem_write%0d: got %b want 1", i, mem_write); else passed++;
    end
    tick();
    cpu_write = 1'b1;
    sample();
    total++; if (BG !== 1'b0) $display("FAIL release_bg: got %b want 0", BG); else passed++;
    total++; if (dma_end !== 1'b1) $display("FAIL release_dma_end: got %b want 1", dma_end); else passed++;
    total++; if (mem_write !== 1'b0) $display("FAIL release_mem_write: got %b want 0", mem_write); else passed++;
    total++; if (mem_addr !== 16'h1000) $display("FAIL release_mem_addr: got %h want 1000", mem_addr); else passed++;
    total++; if (cpu_stall !== 1'b1) $display("FAIL release_stall: got %b want 1", cpu_stall); else passed++;
    tick();
    sample();
    total++; if (dma_end !== 1'b0) $display("FAIL after_release_dma_end: got %b want 0", dma_end); else passed++;
    total++; if (cpu_stall !== 1'b0) $display("FAIL after_release_stall: got %b want 0", cpu_stall); else passed++;
    total++; if (mem_write !== 1'b1) $display("FAIL after_release_mem_write: got %b want 1", mem_write); else passed++;
    cpu_write = 1'b0; dma_write = 1'b0;
  endtask

  task automatic test_cpu_busy();
    cpu_mem_busy = 1'b1; BR = 1'b1; cpu_addr = 16'h2222; cpu_write = 1'b1; dma_write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 2) cpu_mem_busy = 1'b0;
      sample();
      total++; if (BG !== 1'b0) $display("FAIL wait_bg%0d: got %b want 0", i, BG); else passed++;
      total++; if (mem_addr !== 16'h2222) $display("FAIL wait_mem_addr%0d: got %h want 2222", i, mem_addr); else passed++;
      total++; if (mem_write !== 1'b1) $display("FAIL wait_mem_write%0d: got %b want 1", i, mem_write); else passed++;
      total++; if (cpu_stall !== 1'b1) $display("FAIL wait_stall%0d: got %b want 1", i, cpu_stall); else passed++;
    end
    tick();
    BR = 1'b0;
    sample();
    total++; if (BG !== 1'b1) $display("FAIL wait_then_grant: got %b want 1", BG); else passed++;
    total++; if (mem_write !== 1'b0) $display("FAIL wait_grant_mem_write: got %b want 0", mem_write); else passed++;
    tick();
    sample();
    total++; if (dma_end !== 1'b1) $display("FAIL wait_dma_end: got %b want 1", dma_end); else passed++;
    tick();
    cpu_write = 1'b0;
  endtask

  task automatic test_wait_abort();
    cpu_mem_busy = 1'b1; BR = 1'b1;
    tick();
    BR = 1'b0;
    tick();
    sample();
    total++; if (BG !== 1'b0) $display("FAIL abort_bg: got %b want 0", BG); else passed++;
    total++; if (dma_end !== 1'b0) $display("FAIL abort_dma_end: got %b want 0", dma_end); else passed++;
    total++; if (cpu_stall !== 1'b0) $display("FAIL abort_stall: got %b want 0", cpu_stall); else passed++;
    cpu_mem_busy = 1'b0;
    tick();
  endtask

  task automatic test_tie();
    BR = 1'b1; cpu_mem_req = 1'b1;
    sample();
    total++; if (cpu_stall !== 1'b1) $display("FAIL tie_stall: got %b want 1", cpu_stall); else passed++;
    tick();
    BR = 1'b0;
    sample();
    total++; if (BG !== 1'b1) $display("FAIL tie_bg: got %b want 1", BG); else passed++;
    tick();
    sample();
    total++; if (cpu_stall !== 1'b1) $display("FAIL tie_release_stall: got %b want 1", cpu_stall); else passed++;
    tick();
    sample();
    total++; if (cpu_stall !== 1'b0) $display("FAIL tie_cpu_free: got %b want 0", cpu_stall); else passed++;
    cpu_mem_req = 1'b0;
  endtask

  task automatic test_timeout();
    BR = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      sample();
      total++; if (BG !== 1'b1) $display("FAIL timeout_bg%0d: got %b want 1", i, BG); else passed++;
      total++; if (grant_timeout !== 1'b0) $display("FAIL timeout_early%0d: got %b want 0", i, grant_timeout); else passed++;
    end
    tick();
    sample();
    total++; if (BG !== 1'b0) $display("FAIL timeout_bg_drop: got %b want 0", BG); else passed++;
    total++; if (grant_timeout !== 1'b1) $display("FAIL timeout_flag: got %b want 1", grant_timeout); else passed++;
    total++; if (dma_end !== 1'b0) $display("FAIL timeout_no_end: got %b want 0", dma_end); else passed++;
    tick();
    sample();
    total++; if (BG !== 1'b0) $display("FAIL timeout_idle_bg: got %b want 0", BG); else passed++;
    tick();
    BR = 1'b0;
    sample();
    total++; if (BG !== 1'b1) $display("FAIL timeout_regrant: got %b want 1", BG); else passed++;
    tick();
    sample();
    total++; if (dma_end !== 1'b1) $display("FAIL timeout_regrant_end: got %b want 1", dma_end); else passed++;
    total++; if (grant_timeout !== 1'b1) $display("FAIL timeout_sticky: got %b want 1", grant_timeout); else passed++;
    tick();
  endtask

  task automatic test_back_to_back();
    BR = 1'b1;
    tick();
    BR = 1'b0;
    tick();
    BR = 1'b1;
    sample();
    total++; if (dma_end !== 1'b1) $display("FAIL b2b_end: got %b want 1", dma_end); else passed++;
    tick();
    sample();
    total++; if (BG !== 1'b0) $display("FAIL b2b_idle_gap: got %b want 0", BG); else passed++;
    tick();
    sample();
    total++; if (BG !== 1'b1) $display("FAIL b2b_regrant: got %b want 1", BG); else passed++;
  endtask

  task automatic test_reset_mid_grant();
    cpu_write = 1'b1; dma_write = 1'b0;
    reset = 1'b1;
    tick();
    sample();
    total++; if (BG !== 1'b0) $display("FAIL rst_grant_bg: got %b want 0", BG); else passed++;
    total++; if (dma_end !== 1'b0) $display("FAIL rst_grant_end: got %b want 0", dma_end); else passed++;
    total++; if (grant_timeout !== 1'b0) $display("FAIL rst_grant_timeout: got %b want 0", grant_timeout); else passed++;
    total++; if (mem_write !== 1'b1) $display("FAIL rst_grant_mem_write: got %b want 1", mem_write); else passed++;
    BR = 1'b0; reset = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_grant();
    test_cpu_busy();
    test_wait_abort();
    test_tie();
    test_timeout();
    test_back_to_back();
    test_reset_mid_grant();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
